packet_loader_pipe: RTL and testbench

Parametrised successor to the packet loader. It takes a packet request, fetches the packet image from memory as a burst of word reads with up to MAX_OUTSTANDING reads in flight, and assembles the packet, inserting the request tag. It then routes the packet to one of NUM_DEST consumers (queue, function expander, memory accessor, …) selected by the opmode field. It sits between the request sources and the memory controller, and drops and flags packets with an unmapped opmode instead of stalling.

---
 rtl/packet_loader_pipe_if.sv | 54 +++++
 rtl/packet_loader_pipe.sv | 179 +++++++++++++++++
 tb/tb_packet_loader_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_loader_pipe_if.sv
// Handshake bundle between the packet loader, its request source, the
// memory controller and the packet consumers. The loader uses "master".
interface packet_loader_pipe_if #(
  parameter int PR_WIDTH     = 64,
  parameter int WORD_WIDTH   = 32,
  parameter int PACKET_WIDTH = 175,
  parameter int NUM_DEST     = 3
);
  logic                    RECEIVE_PR_VALID;
  logic [PR_WIDTH-1:0]     RECEIVE_PR_DATA;
  logic                    RECEIVE_PR_READY;

  logic                    MEM_SEND_ADDR_VALID;
  logic [31:0]             MEM_SEND_ADDR;
  logic                    MEM_SEND_READY;
  logic                    MEM_SEND_DATA_VALID;
  logic [WORD_WIDTH-1:0]   MEM_SEND_DATA;

  logic                    MEM_RECEIVE_VALID;
  logic [WORD_WIDTH-1:0]   MEM_RECEIVE_DATA;
  logic                    MEM_RECEIVE_READY;

  logic [NUM_DEST-1:0]     SEND_PC_VALID;
  logic [PACKET_WIDTH-1:0] SEND_PC_DATA;
  logic [NUM_DEST-1:0]     SEND_PC_READY;

  logic                    DROP;

  modport master (
    input  RECEIVE_PR_VALID, RECEIVE_PR_DATA,
    output RECEIVE_PR_READY,
    output MEM_SEND_ADDR_VALID, MEM_SEND_ADDR,
    input  MEM_SEND_READY,
    output MEM_SEND_DATA_VALID, MEM_SEND_DATA,
    input  MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
    output MEM_RECEIVE_READY,
    output SEND_PC_VALID, SEND_PC_DATA,
    input  SEND_PC_READY,
    output DROP
  );

  modport slave (
    output RECEIVE_PR_VALID, RECEIVE_PR_DATA,
    input  RECEIVE_PR_READY,
    input  MEM_SEND_ADDR_VALID, MEM_SEND_ADDR,
    output MEM_SEND_READY,
    input  MEM_SEND_DATA_VALID, MEM_SEND_DATA,
    output MEM_RECEIVE_VALID, MEM_RECEIVE_DATA,
    input  MEM_RECEIVE_READY,
    input  SEND_PC_VALID, SEND_PC_DATA,
    output SEND_PC_READY,
    input  DROP
  );
endinterface

// File: rtl/packet_loader_pipe.sv
// Packet loader: takes a packet request, fetches the packet image as a burst
// of in-order word reads with a bounded number in flight, inserts the request
// tag in the packet LSBs and routes the packet to the consumer selected by its
// opmode. Packets whose opmode maps to no consumer are dropped with a pulse.
module packet_loader_pipe #(
  parameter int PR_WIDTH        = 64,
  parameter int PR_ADDR_LSB     = 0,
  parameter int PR_TAG_LSB      = 32,
  parameter int TAG_WIDTH       = 15,
  parameter int PACKET_WIDTH    = 175,
  parameter int WORD_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int NUM_DEST        = 3,
  parameter int OPMODE_LSB      = 170,
  parameter int OPMODE_WIDTH    = 4,
  parameter logic [NUM_DEST*OPMODE_WIDTH-1:0] DEST_CODES = {4'd3, 4'd2, 4'd1}
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] OPADDR,
  packet_loader_pipe_if.master bus
);

  // Memory-fetched part of the packet sits above the tag.
  localparam int DATA_BITS = PACKET_WIDTH - TAG_WIDTH;
  localparam int W         = (DATA_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CW        = $clog2(W + 1);
  localparam int BYTES     = WORD_WIDTH / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  logic [1:0]           r_state;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [DATA_BITS-1:0] r_data;
  logic [CW-1:0]        r_issued;
  logic [CW-1:0]        r_received;
  logic                 r_prReady;
  logic                 r_addrValid;
  logic [31:0]          r_addr;
  logic [NUM_DEST-1:0]  r_pcValid;
  logic                 r_drop;

  logic                    w_addrFire;
  logic                    w_beat;
  logic                    w_lastBeat;
  logic [CW-1:0]           w_issuedNext;
  logic [CW-1:0]           w_receivedNext;
  logic [CW-1:0]           w_outNext;
  logic                    w_addrValidNext;
  logic [DATA_BITS-1:0]    w_slot [W];
  logic [DATA_BITS-1:0]    w_beatSlot;
  logic [DATA_BITS-1:0]    w_dataNext;
  logic [OPMODE_WIDTH-1:0] w_opmode;
  logic                    w_hit;
  logic [NUM_DEST-1:0]     w_destOneHot;
  logic                    w_unusedReq;

  // Only the address and tag fields of the request are consumed.
  assign w_unusedReq = ^bus.RECEIVE_PR_DATA;

  assign w_addrFire = r_addrValid & bus.MEM_SEND_READY;
  assign w_beat     = (r_state == S_FETCH) & bus.MEM_RECEIVE_VALID & (int'(r_received) < W);
  assign w_lastBeat = w_beat & (int'(r_received) == W - 1);

  // Counters are updated net so a slot freed by a beat this cycle can be
  // reused by the address issued at the next edge.
  assign w_issuedNext    = r_issued + CW'(w_addrFire);
  assign w_receivedNext  = r_received + CW'(w_beat);
  assign w_outNext       = w_issuedNext - w_receivedNext;
  assign w_addrValidNext = (int'(w_issuedNext) < W) && (int'(w_outNext) < MAX_OUTSTANDING);

  // Word k lands top-aligned below the previous word; the final word may be
  // clipped at the tag boundary, in which case only its LSBs are kept.
  for (genvar k = 0; k < W; k++) begin : g_slot
    localparam int HI  = DATA_BITS - 1 - k * WORD_WIDTH;
    localparam int LO  = (HI - WORD_WIDTH + 1 > 0) ? (HI - WORD_WIDTH + 1) : 0;
    localparam int LEN = HI - LO + 1;
    assign w_slot[k] = DATA_BITS'(bus.MEM_RECEIVE_DATA[LEN-1:0]) << LO;
  end

  // Pick the placement of the word currently being received.
  always_comb begin
    w_beatSlot = '0;
    for (int k = 0; k < W; k++) begin
      if (int'(r_received) == k) w_beatSlot = w_slot[k];
    end
  end

  // The packet register is cleared at request time, so OR-ing words in is enough.
  assign w_dataNext = r_data | w_beatSlot;
  assign w_opmode   = w_dataNext[OPMODE_LSB-TAG_WIDTH +: OPMODE_WIDTH];

  // Match the opmode against every channel; scanning downwards lets the lowest
  // index win when several channels share a code.
  always_comb begin
    w_hit        = 1'b0;
    w_destOneHot = '0;
    for (int i = NUM_DEST - 1; i >= 0; i--) begin
      if (DEST_CODES[i*OPMODE_WIDTH +: OPMODE_WIDTH] == w_opmode) begin
        w_hit           = 1'b1;
        w_destOneHot    = '0;
        w_destOneHot[i] = 1'b1;
      end
    end
  end

  // Main control: request capture, burst fetch with in-flight limit, routing.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_tag       <= '0;
      r_data      <= '0;
      r_issued    <= '0;
      r_received  <= '0;
      r_prReady   <= 1'b0;
      r_addrValid <= 1'b0;
      r_addr      <= '0;
      r_pcValid   <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_prReady && bus.RECEIVE_PR_VALID) begin
            r_state     <= S_FETCH;
            r_prReady   <= 1'b0;
            r_tag       <= bus.RECEIVE_PR_DATA[PR_TAG_LSB +: TAG_WIDTH];
            r_data      <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_addrValid <= 1'b1;
            r_addr      <= OPADDR + bus.RECEIVE_PR_DATA[PR_ADDR_LSB +: 32];
          end else begin
            r_prReady <= 1'b1;
          end
        end
        S_FETCH: begin
          r_issued   <= w_issuedNext;
          r_received <= w_receivedNext;
          if (w_beat) r_data <= w_dataNext;
          if (w_addrFire) r_addr <= r_addr + 32'(BYTES);
          if (w_lastBeat) begin
            r_addrValid <= 1'b0;
            if (w_hit) begin
              r_state   <= S_SEND;
              r_pcValid <= w_destOneHot;
            end else begin
              r_state <= S_IDLE;
              r_drop  <= 1'b1;
            end
          end else begin
            r_addrValid <= w_addrValidNext;
          end
        end
        S_SEND: begin
          if (|(r_pcValid & bus.SEND_PC_READY)) begin
            r_state   <= S_IDLE;
            r_pcValid <= '0;
            r_prReady <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.RECEIVE_PR_READY    = r_prReady;
  assign bus.MEM_SEND_ADDR_VALID = r_addrValid;
  assign bus.MEM_SEND_ADDR       = r_addr;
  assign bus.MEM_SEND_DATA_VALID = 1'b0;
  assign bus.MEM_SEND_DATA       = '0;
  assign bus.MEM_RECEIVE_READY   = 1'b1;
  assign bus.SEND_PC_VALID       = r_pcValid;
  assign bus.SEND_PC_DATA        = {r_data, r_tag};
  assign bus.DROP                = r_drop;

endmodule

// File: tb/tb_packet_loader_pipe.sv
// Directed bench for packet_loader_pipe. Instance A uses the default build
// (5 words, 4 in flight); instance B uses a 200-bit packet (6 words, last one
// clipped) with at most 2 reads in flight and a slow memory.
// The memory models answer with the read address, with bits [30:27] replaced
// by a per-test opmode so that word 0 carries the wanted routing code.
module tb_packet_loader_pipe;

  logic        clk;
  logic        rstNA, rstNB;
  logic [31:0] opAddrA, opAddrB;

  int checks   = 0;
  int failures = 0;

  packet_loader_pipe_if #(.PACKET_WIDTH(175)) busA ();
  packet_loader_pipe_if #(.PACKET_WIDTH(200)) busB ();

  packet_loader_pipe dutA (
    .CLK(clk), .RST_N(rstNA), .OPADDR(opAddrA), .bus(busA)
  );

  packet_loader_pipe #(
    .PACKET_WIDTH(200), .MAX_OUTSTANDING(2), .OPMODE_LSB(195)
  ) dutB (
    .CLK(clk), .RST_N(rstNB), .OPADDR(opAddrB), .bus(busB)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model state for both instances.
  int          mcA = 0, mcB = 0;
  int          latA = 1, latB = 5;
  logic [3:0]  memOpA = '0, memOpB = '0;
  logic [31:0] qAddrA[$], qAddrB[$];
  int          qDueA[$], qDueB[$];
  logic [31:0] logA[$], logB[$];
  int          logCycA[$];
  int          beatsA = 0;
  int          maxOutB = 0;

  // Memory A: records address handshakes, returns data in order after latA.
  always @(negedge clk) begin
    logic [31:0] a;
    mcA++;
    if (!rstNA) begin
      qAddrA.delete(); qDueA.delete();
      busA.MEM_RECEIVE_VALID = 1'b0;
      busA.MEM_RECEIVE_DATA  = '0;
    end else begin
      if (busA.MEM_SEND_ADDR_VALID && busA.MEM_SEND_READY) begin
        qAddrA.push_back(busA.MEM_SEND_ADDR);
        qDueA.push_back(mcA + latA);
        logA.push_back(busA.MEM_SEND_ADDR);
        logCycA.push_back(mcA);
      end
      if (qAddrA.size() > 0 && qDueA[0] <= mcA) begin
        a = qAddrA.pop_front();
        void'(qDueA.pop_front());
        busA.MEM_RECEIVE_VALID = 1'b1;
        busA.MEM_RECEIVE_DATA  = {a[31], memOpA, a[26:0]};
        beatsA++;
      end else begin
        busA.MEM_RECEIVE_VALID = 1'b0;
      end
    end
  end

  // Memory B: same behaviour, also tracks the peak number of unreturned reads.
  always @(negedge clk) begin
    logic [31:0] a;
    mcB++;
    if (!rstNB) begin
      qAddrB.delete(); qDueB.delete();
      busB.MEM_RECEIVE_VALID = 1'b0;
      busB.MEM_RECEIVE_DATA  = '0;
    end else begin
      if (qAddrB.size() > maxOutB) maxOutB = qAddrB.size();
      if (busB.MEM_SEND_ADDR_VALID && busB.MEM_SEND_READY) begin
        qAddrB.push_back(busB.MEM_SEND_ADDR);
        qDueB.push_back(mcB + latB);
        logB.push_back(busB.MEM_SEND_ADDR);
      end
      if (qAddrB.size() > 0 && qDueB[0] <= mcB) begin
        a = qAddrB.pop_front();
        void'(qDueB.pop_front());
        busB.MEM_RECEIVE_VALID = 1'b1;
        busB.MEM_RECEIVE_DATA  = {a[31], memOpB, a[26:0]};
      end else begin
        busB.MEM_RECEIVE_VALID = 1'b0;
      end
    end
  end

  // Safety net in case a bounded wait is ever defeated.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Wait for request-ready, then present one request for a single cycle.
  task automatic applyStimulus(input bit useB, input logic [31:0] addr, input logic [14:0] tag);
    int n = 0;
    while (n < 30 && !(useB ? busB.RECEIVE_PR_READY : busA.RECEIVE_PR_READY)) begin
      tick(); n++;
    end
    if (n >= 30)
      checkOutput("prReadyTimeout", useB ? busB.RECEIVE_PR_READY : busA.RECEIVE_PR_READY, 1);
    if (useB) begin
      busB.RECEIVE_PR_VALID = 1'b1; busB.RECEIVE_PR_DATA = {17'd0, tag, addr};
    end else begin
      busA.RECEIVE_PR_VALID = 1'b1; busA.RECEIVE_PR_DATA = {17'd0, tag, addr};
    end
    tick();
    busA.RECEIVE_PR_VALID = 1'b0;
    busB.RECEIVE_PR_VALID = 1'b0;
    checkOutput("prReadyDrop", useB ? busB.RECEIVE_PR_READY : busA.RECEIVE_PR_READY, 0);
  endtask

  // Bounded wait for a packet to be offered on any channel.
  task automatic waitPacket(input bit useB, input int budget, output int n);
    n = 0;
    while (n < budget && !(useB ? |busB.SEND_PC_VALID : |busA.SEND_PC_VALID)) begin
      tick(); n++;
    end
    if (n >= budget)
      checkOutput("sendTimeout", useB ? |busB.SEND_PC_VALID : |busA.SEND_PC_VALID, 1);
  endtask

  logic [174:0] expA;
  logic [199:0] expB;
  logic [31:0]  wrapAddr [5] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8};
  int           lat, drops, holdOk, pcHold, hs, b0;
  logic [2:0]   pcSeen;
  bit           stalledPrev;
  int           stalls;

  initial begin
    rstNA = 1'b0; rstNB = 1'b0;
    opAddrA = '0; opAddrB = '0;
    busA.RECEIVE_PR_VALID = 1'b0; busA.RECEIVE_PR_DATA = '0;
    busB.RECEIVE_PR_VALID = 1'b0; busB.RECEIVE_PR_DATA = '0;
    busA.MEM_SEND_READY = 1'b1;   busB.MEM_SEND_READY = 1'b1;
    busA.SEND_PC_READY  = '0;     busB.SEND_PC_READY  = '0;
    repeat (3) tick();

    // Reset values.
    checkOutput("rstPrReady",   busA.RECEIVE_PR_READY, 0);
    checkOutput("rstAddrValid", busA.MEM_SEND_ADDR_VALID, 0);
    checkOutput("rstPcValid",   busA.SEND_PC_VALID, 0);
    checkOutput("rstDrop",      busA.DROP, 0);
    checkOutput("rstPrReadyB",  busB.RECEIVE_PR_READY, 0);
    rstNA = 1'b1; rstNB = 1'b1;
    tick();
    checkOutput("prReadyAfterRst", busA.RECEIVE_PR_READY, 1);

    // Back-to-back fetch to channel 0.
    $display("[TB] back-to-back fetch");
    opAddrA = 32'h1000; memOpA = 4'd1; latA = 1;
    logA.delete(); logCycA.delete();
    applyStimulus(0, 32'h20, 15'h1234);
    checkOutput("t1AddrValidRise", busA.MEM_SEND_ADDR_VALID, 1);
    checkOutput("t1FirstAddr", busA.MEM_SEND_ADDR, 32'h1020);
    waitPacket(0, 30, lat);
    checkOutput("t1Latency", 32'(lat), 6);
    expA = {32'h08001020, 32'h08001024, 32'h08001028, 32'h0800102C, 32'h08001030, 15'h1234};
    checkOutput("t1PcValid", busA.SEND_PC_VALID, 3'b001);
    checkOutput("t1Data", busA.SEND_PC_DATA, expA);
    checkOutput("t1Tag", busA.SEND_PC_DATA[14:0], 15'h1234);
    checkOutput("t1AddrCount", 32'(logA.size()), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t1Addr%0d", i), logA[i], 32'h1020 + 32'(4 * i));
    checkOutput("t1Spacing", 32'(logCycA[4] - logCycA[0]), 4);
    busA.SEND_PC_READY = 3'b001;
    tick();
    busA.SEND_PC_READY = '0;
    checkOutput("t1PcValidDone", busA.SEND_PC_VALID, 0);
    checkOutput("t1PrReadyBack", busA.RECEIVE_PR_READY, 1);

    // Unmapped opmode is dropped.
    $display("[TB] unmapped opmode");
    memOpA = 4'd7;
    applyStimulus(0, 32'h40, 15'h0001);
    drops = 0; pcSeen = '0;
    for (int i = 0; i < 15; i++) begin
      if (busA.DROP) drops++;
      pcSeen |= busA.SEND_PC_VALID;
      tick();
    end
    checkOutput("t3DropCount", 32'(drops), 1);
    checkOutput("t3NoSend", pcSeen, 0);
    checkOutput("t3PrReady", busA.RECEIVE_PR_READY, 1);

    // Address and output backpressure, channel 1.
    $display("[TB] backpressure");
    memOpA = 4'd2;
    logA.delete();
    applyStimulus(0, 32'h100, 15'h7FFF);
    stalls = 0; holdOk = 0; stalledPrev = 1'b0;
    for (int n = 0; n < 40 && busA.SEND_PC_VALID == '0; n++) begin
      if (stalledPrev && busA.MEM_SEND_ADDR_VALID && busA.MEM_SEND_ADDR == 32'h1108) holdOk++;
      if (busA.MEM_SEND_ADDR_VALID && busA.MEM_SEND_ADDR == 32'h1108 && stalls < 3) begin
        busA.MEM_SEND_READY = 1'b0; stalls++; stalledPrev = 1'b1;
      end else begin
        busA.MEM_SEND_READY = 1'b1; stalledPrev = 1'b0;
      end
      tick();
    end
    busA.MEM_SEND_READY = 1'b1;
    checkOutput("t4AddrHold", 32'(holdOk), 3);
    checkOutput("t4AddrCount", 32'(logA.size()), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t4Addr%0d", i), logA[i], 32'h1100 + 32'(4 * i));
    expA = {32'h10001100, 32'h10001104, 32'h10001108, 32'h1000110C, 32'h10001110, 15'h7FFF};
    busA.SEND_PC_READY = 3'b101;
    pcHold = 0;
    for (int i = 0; i < 4; i++) begin
      if (busA.SEND_PC_VALID == 3'b010 && busA.SEND_PC_DATA == expA) pcHold++;
      tick();
    end
    checkOutput("t4PcHold", 32'(pcHold), 4);
    busA.SEND_PC_READY = 3'b010;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      if (|(busA.SEND_PC_VALID & busA.SEND_PC_READY)) hs++;
      tick();
    end
    busA.SEND_PC_READY = '0;
    checkOutput("t4Handshakes", 32'(hs), 1);

    // Address wrap, channel 2.
    $display("[TB] address wrap");
    opAddrA = 32'hFFFFFFF8; memOpA = 4'd3;
    logA.delete();
    applyStimulus(0, 32'h0, 15'h0055);
    waitPacket(0, 30, lat);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t5Addr%0d", i), logA[i], wrapAddr[i]);
    expA = {32'h9FFFFFF8, 32'h9FFFFFFC, 32'h18000000, 32'h18000004, 32'h18000008, 15'h0055};
    checkOutput("t5PcValid", busA.SEND_PC_VALID, 3'b100);
    checkOutput("t5Data", busA.SEND_PC_DATA, expA);
    busA.SEND_PC_READY = 3'b100;
    tick();
    busA.SEND_PC_READY = '0;

    // Reset in the middle of a fetch, then a clean request.
    $display("[TB] reset mid-fetch");
    opAddrA = 32'h1000; memOpA = 4'd1;
    applyStimulus(0, 32'h200, 15'h0101);
    b0 = beatsA;
    for (int n = 0; n < 20 && (beatsA - b0) < 3; n++) tick();
    rstNA = 1'b0;
    drops = 0;
    repeat (2) begin
      tick();
      if (busA.DROP) drops++;
    end
    checkOutput("t6RstPrReady",   busA.RECEIVE_PR_READY, 0);
    checkOutput("t6RstAddrValid", busA.MEM_SEND_ADDR_VALID, 0);
    checkOutput("t6RstPcValid",   busA.SEND_PC_VALID, 0);
    checkOutput("t6RstDrop",      32'(drops), 0);
    rstNA = 1'b1;
    tick();
    checkOutput("t6PrReadyAfterRst", busA.RECEIVE_PR_READY, 1);
    logA.delete();
    applyStimulus(0, 32'h300, 15'h2222);
    waitPacket(0, 30, lat);
    expA = {32'h08001300, 32'h08001304, 32'h08001308, 32'h0800130C, 32'h08001310, 15'h2222};
    checkOutput("t6PcValid", busA.SEND_PC_VALID, 3'b001);
    checkOutput("t6Data", busA.SEND_PC_DATA, expA);
    busA.SEND_PC_READY = 3'b001;
    tick();
    busA.SEND_PC_READY = '0;

    // In-flight limit of 2 with slow memory; six words, last one clipped.
    $display("[TB] outstanding limit");
    opAddrB = 32'h2000; memOpB = 4'd1; latB = 5; maxOutB = 0;
    logB.delete();
    applyStimulus(1, 32'h40, 15'h0ABC);
    waitPacket(1, 100, lat);
    checkOutput("t2MaxOutstanding", 32'(maxOutB), 2);
    checkOutput("t2AddrCount", 32'(logB.size()), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t2Addr%0d", i), logB[i], 32'h2040 + 32'(4 * i));
    expB = {32'h08002040, 32'h08002044, 32'h08002048, 32'h0800204C, 32'h08002050,
            25'h0002054, 15'h0ABC};
    checkOutput("t2PcValid", busB.SEND_PC_VALID, 3'b001);
    checkOutput("t2Data", busB.SEND_PC_DATA, expB);
    busB.SEND_PC_READY = 3'b001;
    tick();
    busB.SEND_PC_READY = '0;
    checkOutput("t2PcValidDone", busB.SEND_PC_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
